// File: rtl/parity_serial_transmitter.sv
// parity_serial_transmitter
// Serializes one byte as an I2C-style frame: START, 8 data bits MSB first,
// an even-parity bit (XOR of the byte), an ACK slot and STOP. Every non-idle
// bit lasts CLK_DIV fast-clock cycles. SERIAL_CLOCK and SERIAL_DATA are
// registered: they are computed from the next state so that each output
// cycle reflects the state/counter of that same cycle.
//
// CLK_DIV must be even and >= 4 so that the half-period split of each bit
// is exact; DATA_WIDTH is fixed at 8 in this revision.

module parity_serial_transmitter #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  FAST_CLOCK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DATA_INPUT_TX,
    input  logic                  TX_START,
    input  logic                  ACK_IN,
    output logic                  SERIAL_CLOCK,
    output logic                  SERIAL_DATA,
    output logic                  PARITY_BIT_OUT,
    output logic                  TX_BUSY,
    output logic                  TX_DONE,
    output logic                  TX_ACK_ERROR
);

    // Counter widths and compare points are fixed at elaboration.
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_ACK,
        S_STOP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [DATA_WIDTH-1:0]   tx_byte;

    state_t                  nxt_state;
    logic [CNT_W-1:0]        nxt_cnt;
    logic [IDX_W-1:0]        nxt_idx;
    logic [DATA_WIDTH-1:0]   nxt_byte;
    logic                    nxt_par;

    logic                    accept;
    logic                    bit_end;
    logic                    ack_sample;

    assign accept     = (state == S_IDLE) && TX_START;
    assign bit_end    = (cnt == CNT_LAST);
    assign ack_sample = (state == S_ACK) && (cnt == CNT_HALF);

    // Serial clock level for a given state and cycle position: held high
    // through IDLE and START, low then high within every later bit period.
    function automatic logic scl_for(input state_t st, input logic [CNT_W-1:0] c);
        logic v;
        v = 1'b1;
        if (st != S_IDLE && st != S_START)
            v = (c >= CNT_HALF);
        return v;
    endfunction

    // Serial data level for a given state and cycle position. START falls and
    // STOP rises in the clock-high half so they read as start/stop conditions.
    function automatic logic sda_for(input state_t                st,
                                     input logic [CNT_W-1:0]      c,
                                     input logic [DATA_WIDTH-1:0] b,
                                     input logic [IDX_W-1:0]      idx,
                                     input logic                  par);
        logic v;
        v = 1'b1;
        case (st)
            S_IDLE:   v = 1'b1;
            S_START:  v = (c < CNT_HALF);
            S_DATA:   v = b[IDX_LAST - idx];
            S_PARITY: v = par;
            S_ACK:    v = 1'b1;
            S_STOP:   v = (c == CNT_LAST);
            default:  v = 1'b1;
        endcase
        return v;
    endfunction

    // Next-state, counter and latched-byte logic; the FSM register below
    // consumes these so registered outputs can be derived from them.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = bit_idx;
        nxt_byte  = tx_byte;
        nxt_par   = PARITY_BIT_OUT;
        if (state == S_IDLE) begin
            if (TX_START) begin
                nxt_state = S_START;
                nxt_cnt   = '0;
                nxt_idx   = '0;
                nxt_byte  = DATA_INPUT_TX;
                nxt_par   = ^DATA_INPUT_TX;
            end
        end else if (!bit_end) begin
            nxt_cnt = cnt + CNT_W'(1);
        end else begin
            nxt_cnt = '0;
            case (state)
                S_START: begin
                    nxt_state = S_DATA;
                    nxt_idx   = '0;
                end
                S_DATA: begin
                    if (bit_idx == IDX_LAST)
                        nxt_state = S_PARITY;
                    else
                        nxt_idx = bit_idx + IDX_W'(1);
                end
                S_PARITY: nxt_state = S_ACK;
                S_ACK:    nxt_state = S_STOP;
                S_STOP:   nxt_state = S_IDLE;
                default:  nxt_state = S_IDLE;
            endcase
        end
    end

    // Frame FSM with registered serial lines and status flags.
    always_ff @(posedge FAST_CLOCK or posedge RESET) begin
        if (RESET) begin
            state          <= S_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            tx_byte        <= '0;
            PARITY_BIT_OUT <= 1'b0;
            SERIAL_CLOCK   <= 1'b1;
            SERIAL_DATA    <= 1'b1;
            TX_BUSY        <= 1'b0;
            TX_DONE        <= 1'b0;
            TX_ACK_ERROR   <= 1'b0;
        end else begin
            state          <= nxt_state;
            cnt            <= nxt_cnt;
            bit_idx        <= nxt_idx;
            tx_byte        <= nxt_byte;
            PARITY_BIT_OUT <= nxt_par;
            SERIAL_CLOCK   <= scl_for(nxt_state, nxt_cnt);
            SERIAL_DATA    <= sda_for(nxt_state, nxt_cnt, nxt_byte, nxt_idx, nxt_par);
            TX_BUSY        <= (nxt_state != S_IDLE);
            // Done pulses on the edge that closes STOP; the next edge is in
            // IDLE, so the pulse is exactly one cycle even on a back-to-back
            // accept.
            TX_DONE        <= (state == S_STOP) && bit_end;
            // Error flag is cleared by a new accept and set only by a NACK
            // seen at the mid-point of the ACK slot; it is sticky otherwise.
            if (accept)
                TX_ACK_ERROR <= 1'b0;
            else if (ack_sample && ACK_IN)
                TX_ACK_ERROR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_serial_transmitter.sv
// Scoreboard bench for parity_serial_transmitter. On every accepted frame the
// stimulus pushes the expected per-cycle bus picture (derived from the frame
// layout rules) into a queue; a negedge monitor pops and compares while busy
// and checks idle / done behaviour otherwise.

module tb_parity_serial_transmitter;

    localparam int D = 4;
    localparam int H = D / 2;
    localparam int FRAME = 12 * D;

    logic       FAST_CLOCK = 1'b0;
    logic       RESET;
    logic [7:0] DATA_INPUT_TX;
    logic       TX_START;
    logic       ACK_IN;
    logic       SERIAL_CLOCK;
    logic       SERIAL_DATA;
    logic       PARITY_BIT_OUT;
    logic       TX_BUSY;
    logic       TX_DONE;
    logic       TX_ACK_ERROR;

    parity_serial_transmitter #(.CLK_DIV(D), .DATA_WIDTH(8)) dut (
        .FAST_CLOCK     (FAST_CLOCK),
        .RESET          (RESET),
        .DATA_INPUT_TX  (DATA_INPUT_TX),
        .TX_START       (TX_START),
        .ACK_IN         (ACK_IN),
        .SERIAL_CLOCK   (SERIAL_CLOCK),
        .SERIAL_DATA    (SERIAL_DATA),
        .PARITY_BIT_OUT (PARITY_BIT_OUT),
        .TX_BUSY        (TX_BUSY),
        .TX_DONE        (TX_DONE),
        .TX_ACK_ERROR   (TX_ACK_ERROR)
    );

    always #5 FAST_CLOCK = ~FAST_CLOCK;

    typedef struct packed {
        logic scl;
        logic sda;
        logic par;
        logic err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: expected bus for each of the 12*D busy cycles of one frame.
    task automatic push_frame(input logic [7:0] b, input logic ack);
        logic par;
        exp_t e;
        par = logic'($countones(b) % 2);
        for (int i = 0; i < FRAME; i++) begin
            int p;
            int c;
            p = i / D;
            c = i % D;
            e.par = par;
            e.err = (i > 10 * D + H) ? ack : 1'b0;
            e.scl = (p == 0) ? 1'b1 : (c >= H);
            if (p == 0)       e.sda = (c < H);
            else if (p <= 8)  e.sda = b[8 - p];
            else if (p == 9)  e.sda = par;
            else if (p == 10) e.sda = 1'b1;
            else              e.sda = (c == D - 1);
            q.push_back(e);
        end
    endtask

    // Monitor: compares away from the active edge.
    logic prev_busy = 1'b0;
    int   run = 0;
    logic exp_par = 1'b0;
    logic exp_err = 1'b0;

    always @(negedge FAST_CLOCK) begin
        if (RESET) begin
            check("reset_outputs",
                  {SERIAL_CLOCK, SERIAL_DATA, PARITY_BIT_OUT, TX_BUSY, TX_DONE, TX_ACK_ERROR},
                  6'b110000);
            q.delete();
            prev_busy = 1'b0;
            run = 0;
            exp_par = 1'b0;
            exp_err = 1'b0;
        end else if (TX_BUSY) begin
            if (q.size() == 0) begin
                check("unexpected_busy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("bus_busy", {SERIAL_CLOCK, SERIAL_DATA, PARITY_BIT_OUT, TX_ACK_ERROR}, e);
                check("done_while_busy", TX_DONE, 1'b0);
                exp_par = e.par;
                exp_err = e.err;
            end
            run++;
            prev_busy = 1'b1;
        end else begin
            if (prev_busy) begin
                check("done_pulse", TX_DONE, 1'b1);
                check("busy_length", run, FRAME);
                check("queue_drained", q.size(), 0);
            end else begin
                check("no_stray_done", TX_DONE, 1'b0);
            end
            check("bus_idle", {SERIAL_CLOCK, SERIAL_DATA, PARITY_BIT_OUT, TX_ACK_ERROR},
                  {2'b11, exp_par, exp_err});
            prev_busy = 1'b0;
            run = 0;
        end
    end

    // All stimulus runs at posedge+1.
    task automatic wait_idle();
        int n = 0;
        while (TX_BUSY && n < 200) begin
            @(posedge FAST_CLOCK); #1;
            n++;
        end
        if (TX_BUSY) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input logic ack);
        wait_idle();
        DATA_INPUT_TX = b;
        ACK_IN = ack;
        TX_START = 1'b1;
        @(posedge FAST_CLOCK); #1;
        push_frame(b, ack);
        TX_START = 1'b0;
        DATA_INPUT_TX = 8'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        TX_START = 1'b0;
        DATA_INPUT_TX = 8'h00;
        ACK_IN = 1'b0;
        repeat (3) @(posedge FAST_CLOCK);
        #1 RESET = 1'b0;
        @(posedge FAST_CLOCK); #1;

        // Known pattern, even parity.
        send(8'hA5, 1'b0);
        check("parity_a5", PARITY_BIT_OUT, 1'b0);
        check("busy_after_accept", TX_BUSY, 1'b1);

        // Odd parity, ACK given.
        send(8'h07, 1'b0);
        check("parity_07", PARITY_BIT_OUT, 1'b1);
        wait_idle();
        check("ack_ok_07", TX_ACK_ERROR, 1'b0);

        // NACK: sticky flag, then cleared by the next accept.
        send(8'h3C, 1'b1);
        wait_idle();
        repeat (3) @(posedge FAST_CLOCK);
        #1 check("ack_err_held", TX_ACK_ERROR, 1'b1);
        send(8'h5A, 1'b0);
        check("ack_err_cleared", TX_ACK_ERROR, 1'b0);

        // Start pulse while busy is ignored.
        send(8'h96, 1'b0);
        repeat (10) @(posedge FAST_CLOCK);
        #1;
        DATA_INPUT_TX = 8'hFF;
        TX_START = 1'b1;
        @(posedge FAST_CLOCK); #1;
        TX_START = 1'b0;
        check("parity_kept_96", PARITY_BIT_OUT, 1'b0);

        // Start held high: second frame accepted in the done cycle.
        wait_idle();
        DATA_INPUT_TX = 8'h81;
        ACK_IN = 1'b0;
        TX_START = 1'b1;
        @(posedge FAST_CLOCK); #1;
        push_frame(8'h81, 1'b0);
        DATA_INPUT_TX = 8'h42;
        begin
            int n = 0;
            while (!TX_DONE && n < 200) begin
                @(posedge FAST_CLOCK); #1;
                n++;
            end
            check("held_done_seen", TX_DONE, 1'b1);
        end
        check("held_gap_busy_low", TX_BUSY, 1'b0);
        @(posedge FAST_CLOCK); #1;
        push_frame(8'h42, 1'b0);
        check("held_rebusy", TX_BUSY, 1'b1);
        TX_START = 1'b0;

        // Asynchronous reset at cycle 20 of a frame.
        send(8'hC3, 1'b1);
        repeat (19) @(posedge FAST_CLOCK);
        #1 RESET = 1'b1;
        #1;
        check("async_rst_scl", SERIAL_CLOCK, 1'b1);
        check("async_rst_sda", SERIAL_DATA, 1'b1);
        check("async_rst_busy", TX_BUSY, 1'b0);
        check("async_rst_done", TX_DONE, 1'b0);
        @(posedge FAST_CLOCK); #1;
        RESET = 1'b0;
        repeat (3) @(posedge FAST_CLOCK);
        #1;
        send(8'hE7, 1'b0);

        // Randomized frames.
        for (int k = 0; k < 8; k++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 30)) @(posedge FAST_CLOCK);
                #1 DATA_INPUT_TX = 8'($urandom);
            end
        end

        wait_idle();
        repeat (4) @(posedge FAST_CLOCK);
        #1;
        check("final_queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_serial_transmitter.md
Name: parity_serial_transmitter

Overview:
Transmit-side counterpart of the controller's parity-checked byte receive path. Accepts a byte on a start strobe and computes its parity bit, the XOR of all 8 data bits. Serializes an I2C-style frame on SERIAL_CLOCK/SERIAL_DATA: START, 8 data bits MSB first, parity bit, ACK slot, STOP. Sits in I2C_CONTROLLER next to the receive checker; the receiver validates with data XOR == parity bit.

Parameters:
CLK_DIV, 4, FAST_CLOCK cycles per serial bit period; must be even and >= 4
DATA_WIDTH, 8, data bits per frame; fixed at 8 for this revision

Ports:
FAST_CLOCK  input  1  system clock, all logic on posedge
RESET  input  1  asynchronous, active-high reset
DATA_INPUT_TX  input  8  byte to transmit, sampled at accept
TX_START  input  1  request; accepted when sampled high in IDLE
ACK_IN  input  1  receiver acknowledge, 0 = ACK, sampled in ACK slot
SERIAL_CLOCK  output  1  serial clock (SCL-like), registered
SERIAL_DATA  output  1  serial data (SDA-like), registered
PARITY_BIT_OUT  output  1  parity of latched byte (XOR of bits 7..0)
TX_BUSY  output  1  high for the whole frame
TX_DONE  output  1  one-cycle pulse at end of frame
TX_ACK_ERROR  output  1  sticky: last frame got ACK_IN=1

Behaviour:
- Reset values (RESET high, async): state IDLE; SERIAL_CLOCK=1, SERIAL_DATA=1; PARITY_BIT_OUT=0, TX_BUSY=0, TX_DONE=0, TX_ACK_ERROR=0; bit/cycle counters 0. RESET mid-frame aborts immediately, with no TX_DONE.
- States: IDLE -> START -> DATA (8 bits) -> PARITY -> ACK -> STOP -> IDLE. Each non-IDLE bit occupies exactly CLK_DIV cycles, tracked by cycle counter cnt = 0..CLK_DIV-1.
- Accept: edge where state=IDLE and TX_START=1.
  - At that edge: latch DATA_INPUT_TX into a shift register; PARITY_BIT_OUT <= XOR of the byte; TX_ACK_ERROR <= 0; TX_BUSY <= 1; state <= START, cnt=0.
  - TX_START while not IDLE is ignored. It is accepted in the TX_DONE cycle, since state is IDLE then.
- SERIAL_CLOCK:
  - 1 throughout IDLE and START.
  - In DATA, PARITY, ACK and STOP: 0 for cnt < CLK_DIV/2, 1 for cnt >= CLK_DIV/2.
- SERIAL_DATA:
  - IDLE: 1.
  - START: 1 for cnt < CLK_DIV/2, 0 afterwards (falls while clock high).
  - DATA: current bit, MSB first, constant over the whole bit period.
  - PARITY: PARITY_BIT_OUT.
  - ACK: 1 (released).
  - STOP: 0, except 1 on cnt = CLK_DIV-1 (rises while clock high).
- ACK sampling: ACK_IN sampled on the edge where state=ACK and cnt=CLK_DIV/2. A value of 1 sets TX_ACK_ERROR, held until the next accept. The frame always completes; there is no retry.
- Timing:
  - TX_BUSY is high for exactly 12*CLK_DIV cycles, starting the cycle after the accept edge.
  - On the edge ending STOP: TX_BUSY <= 0, TX_DONE <= 1, state <= IDLE.
  - TX_DONE clears on the following edge.
  - With CLK_DIV=4: 48 busy cycles, then a 1-cycle TX_DONE.
- PARITY_BIT_OUT and the latched byte are held stable until the next accept. DATA_INPUT_TX changes mid-frame have no effect.
- CLK_DIV/2 and the counter widths are derived from CLK_DIV at elaboration; no runtime division.

Test Plan:
- Reset, then TX_START with 0xA5 (CLK_DIV=4) -> PARITY_BIT_OUT=0. SERIAL_DATA on successive bit periods reads 1,0,1,0,0,1,0,1 then parity 0. TX_BUSY high 48 cycles, then TX_DONE for 1 cycle.
- 0x07 with ACK_IN=0 -> PARITY_BIT_OUT=1. Parity slot drives SERIAL_DATA=1. TX_ACK_ERROR stays 0.
- 0x3C with ACK_IN=1 in ACK slot -> TX_ACK_ERROR=1 after sample edge, held through IDLE. Next accept clears it to 0.
- TX_START pulsed again with 0xFF while TX_BUSY=1 -> ignored; frame continues with original byte; single TX_DONE.
- TX_START held high continuously with 0x81 -> second frame accepted in the TX_DONE cycle. TX_BUSY low for exactly that 1 cycle, then high for another 48.
- RESET asserted at cycle 20 of a frame -> SERIAL_CLOCK=1, SERIAL_DATA=1, TX_BUSY=0 immediately (asynchronous). No TX_DONE. A new TX_START after release starts a clean frame.
